lift_motion_door_sequencer: RTL

Cycle-level car/door sequencer for the lift controller. It owns the car position (one-hot floor vector plus binary index), the inter-floor travel timer and the door open/close timer. It consumes motion/direction/stop decisions from the main ALU block and produces the i_flr_pos and i_door_open stimuli that feed it. A close-guard window keeps the ALU's request-clear pulse from being re-sampled as a new stop.

---
 rtl/lift_motion_door_sequencer_if.sv | 33 +++
 rtl/lift_motion_door_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lift_motion_door_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lift_motion_door_sequencer_if                                      |
// | ALU-side decision inputs and car/door status outputs of the        |
// | lift motion/door sequencer.                                        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface lift_motion_door_sequencer_if #(
  parameter int N_FLOORS = 12
);
  localparam int FW = $clog2(N_FLOORS);

  logic                i_motion;
  logic                i_direction;
  logic                i_has_rqst_at_stopped_flr;
  logic                i_door_hold;
  logic [N_FLOORS-1:0] o_flr_pos;
  logic [FW-1:0]       o_curr_flr;
  logic                o_door_open;
  logic [1:0]          o_state;
  logic                o_limit_err;

  modport master (
    output i_motion, i_direction, i_has_rqst_at_stopped_flr, i_door_hold,
    input  o_flr_pos, o_curr_flr, o_door_open, o_state, o_limit_err
  );

  modport slave (
    input  i_motion, i_direction, i_has_rqst_at_stopped_flr, i_door_hold,
    output o_flr_pos, o_curr_flr, o_door_open, o_state, o_limit_err
  );
endinterface
`default_nettype wire

// File: rtl/lift_motion_door_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lift_motion_door_sequencer                                         |
// | Car position, travel timer and door timer sequencer for the lift   |
// | controller. Optional door reversal in CLOSE: DOOR_REOPEN_EN.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module lift_motion_door_sequencer #(
  parameter int N_FLOORS           = 12,
  parameter int TRAVEL_CYCLES      = 8,
  parameter int DOOR_OPEN_CYCLES   = 16,
  parameter int CLOSE_GUARD_CYCLES = 2
) (
  input  wire                          clk,
  input  wire                          reset,
  lift_motion_door_sequencer_if.slave  bus
);

  localparam int FW    = $clog2(N_FLOORS);
  localparam int MAX_A = (TRAVEL_CYCLES > DOOR_OPEN_CYCLES) ? TRAVEL_CYCLES : DOOR_OPEN_CYCLES;
  localparam int MAX_C = (MAX_A > CLOSE_GUARD_CYCLES) ? MAX_A : CLOSE_GUARD_CYCLES;
  localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [TW-1:0]       T_TRAVEL = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0]       T_OPEN   = TW'(DOOR_OPEN_CYCLES - 1);
  localparam logic [TW-1:0]       T_GUARD  = TW'(CLOSE_GUARD_CYCLES - 1);
  localparam logic [FW-1:0]       TOP_FLR  = FW'(N_FLOORS - 1);
  localparam logic [N_FLOORS-1:0] FLR0_OH  = N_FLOORS'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_CLOSE = 2'd2,
    ST_MOVE  = 2'd3
  } state_t;

  state_t              state_q,     state_d;
  logic [TW-1:0]       timer_q,     timer_d;
  logic [FW-1:0]       curr_flr_q,  curr_flr_d;
  logic [N_FLOORS-1:0] flr_pos_q,   flr_pos_d;
  logic                door_open_q, door_open_d;
  logic                limit_err_q, limit_err_d;
  logic                dir_q,       dir_d;

  logic                move_legal;
  logic [FW-1:0]       next_flr;

  assign move_legal = bus.i_direction ? (curr_flr_q != TOP_FLR) : (curr_flr_q != '0);
  assign next_flr   = dir_q ? (curr_flr_q + FW'(1)) : (curr_flr_q - FW'(1));

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    curr_flr_d  = curr_flr_q;
    flr_pos_d   = flr_pos_q;
    door_open_d = door_open_q;
    limit_err_d = 1'b0;
    dir_d       = dir_q;

    case (state_q)
      ST_IDLE: begin
        // A stop at the current floor outranks any motion request.
        if (bus.i_has_rqst_at_stopped_flr) begin
          state_d     = ST_OPEN;
          timer_d     = T_OPEN;
          door_open_d = 1'b1;
        end else if (bus.i_motion) begin
          if (move_legal) begin
            state_d   = ST_MOVE;
            timer_d   = T_TRAVEL;
            dir_d     = bus.i_direction;
            flr_pos_d = '0;
          end else begin
            limit_err_d = 1'b1;
          end
        end
      end

      ST_MOVE: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          curr_flr_d = next_flr;
          flr_pos_d  = FLR0_OH << next_flr;
          state_d    = ST_IDLE;
        end
      end

      ST_OPEN: begin
        if (bus.i_door_hold) begin
          timer_d = T_OPEN;
        end else if (timer_q == '0) begin
          state_d     = ST_CLOSE;
          timer_d     = T_GUARD;
          door_open_d = 1'b0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      ST_CLOSE: begin
        // Stop/motion inputs are masked here so the ALU's request-clear
        // pulse is not re-sampled as a fresh stop.
`ifdef DOOR_REOPEN_EN
        if (bus.i_door_hold) begin
          state_d     = ST_OPEN;
          timer_d     = T_OPEN;
          door_open_d = 1'b1;
        end else
`endif
        if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      curr_flr_q  <= '0;
      flr_pos_q   <= FLR0_OH;
      door_open_q <= 1'b0;
      limit_err_q <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      curr_flr_q  <= curr_flr_d;
      flr_pos_q   <= flr_pos_d;
      door_open_q <= door_open_d;
      limit_err_q <= limit_err_d;
      dir_q       <= dir_d;
    end
  end

  assign bus.o_flr_pos   = flr_pos_q;
  assign bus.o_curr_flr  = curr_flr_q;
  assign bus.o_door_open = door_open_q;
  assign bus.o_state     = state_q;
  assign bus.o_limit_err = limit_err_q;

endmodule
`default_nettype wire
